fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: FIFO write data width.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum words per grant (1..16).
REQ-004 SHALL have port W_CLK, input, 1: write-domain clock; all state on rising edge.
REQ-005 SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester word-available.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready, output, NUM_REQ: per-requester word-accepted qualifier.
REQ-009 SHALL have port FULL_flag, input, 1: FIFO full, write domain.
REQ-010 SHALL have port Winc, output, 1: FIFO write enable.
REQ-011 SHALL have port WR_DATA, output, DATA_WIDTH: FIFO write data.
REQ-012 SHALL have port grant_id, output, clog2(NUM_REQ): registered index of current owner.
REQ-013 SHALL have port busy, output, 1: high while state is BURST.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, BURST.
REQ-015 IDLE: if any req_valid high, SHALL latch grant_id as first valid index searching round-robin from last_grant+1 (wrapping NUM_REQ-1 to 0), clear beat counter, enter BURST next cycle; else stay IDLE.
REQ-016 BURST: req_ready[grant_id] SHALL equal !FULL_flag combinationally; all other req_ready bits SHALL be 0; all bits 0 in IDLE.
REQ-017 Winc SHALL equal req_valid[grant_id] & req_ready[grant_id] (combinational, zero latency) so FULL_flag gates the write in the same cycle.
REQ-018 WR_DATA SHALL be the req_data slice of grant_id in BURST, 0 in IDLE.
REQ-019 Each Winc cycle SHALL increment the beat counter (width clog2(MAX_BURST)+1).
REQ-020 BURST SHALL exit to IDLE after the transfer that makes the beat count MAX_BURST, or on any cycle req_valid[grant_id] is low; last_grant SHALL take grant_id on exit.
REQ-021 FULL_flag high in BURST SHALL stall without counting beats and without exiting while req_valid[grant_id] stays high.
REQ-022 One IDLE arbitration cycle SHALL separate consecutive bursts.
REQ-023 Only requester grant_id is observed in BURST; new req_valid edges elsewhere SHALL not alter the grant.

Reset
REQ-024 RST low SHALL asynchronously force state IDLE, grant_id 0, last_grant NUM_REQ-1 (so requester 0 wins first), beat counter 0, Winc 0, req_ready 0, busy 0.
REQ-025 Reset mid-burst SHALL drop Winc in the same cycle; no partial-word write after release.

Configuration
REQ-026 With macro FIFO_WR_ARB_STATS_EN defined, SHALL add output stall_cnt, 16 bits, counting cycles in BURST with req_valid[grant_id] & FULL_flag, saturating at 16'hFFFF, reset to 0.
REQ-027 Without FIFO_WR_ARB_STATS_EN, the stall_cnt port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-028 SHALL place FSM state encoding (IDLE=1'b0, BURST=1'b1) and the default parameter constants in shared package fifo_wr_pkg.
REQ-029 SHALL implement the round-robin search in sub-module rr_pick (inputs: request vector, last index; output: winner index, any-valid).

Verification
REQ-030 Only req_valid[2]=1, FULL_flag=0, 6 words queued -> IDLE 1 cycle, 4 Winc pulses with grant_id=2, IDLE 1 cycle, 2 more Winc pulses.
REQ-031 All four req_valid=1 continuously after reset -> grant_id sequence 0,1,2,3,0, each burst exactly 4 Winc pulses.
REQ-032 Grant 1 mid-burst after 2 words, FULL_flag=1 for 5 cycles -> Winc=0, req_ready[1]=0, busy=1 throughout; words 3-4 written after FULL drops; stall_cnt=5 when STATS enabled.
REQ-033 req_valid[3] drops after 1 word -> BURST exits next edge, next grant goes to lowest valid index after 3 (wrapping to 0).
REQ-034 RST asserted during beat 2 of a burst -> Winc, req_ready, busy go 0 immediately; after release requester 0 granted first.

Source files
------------

// File: rtl/fifo_wr_pkg.sv
// Shared package for the FIFO write arbiter: FSM state encoding and
// default parameter values.
package fifo_wr_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner search: first set request bit strictly after last_i,
// wrapping from N-1 back to 0. last_i itself is checked last.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] winner_o,
  output logic          any_o
);

  // Walk candidates farthest-first so the nearest one after last_i wins.
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N;
      if (req_i[idx]) begin
        winner_o = IW'(idx);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an async FIFO write port.
// Grants one requester per burst of up to MAX_BURST words; FULL_flag
// gates writes in the same cycle. Optional macro FIFO_WR_ARB_STATS_EN
// adds a saturating stall counter output (stall_cnt).
module fifo_wr_arbiter
  import fifo_wr_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic                          W_CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          FULL_flag,
  output logic                          Winc,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          own_valid;

  rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick (
    .req_i    (req_valid),
    .last_i   (last_q),
    .winner_o (pick_idx),
    .any_o    (pick_any)
  );

  assign own_valid = req_valid[grant_q];
  assign grant_id  = grant_q;
  assign busy      = (state_q == BURST);

  // State, owner, round-robin pointer and beat counter registers.
  always_ff @(posedge W_CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs and next state; write handshake is purely combinational so a
  // reset or FULL_flag kills Winc in the same cycle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    beat_d    = beat_q;
    req_ready = '0;
    Winc      = 1'b0;
    WR_DATA   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready[grant_q] = !FULL_flag;
        Winc               = own_valid && !FULL_flag;
        WR_DATA            = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        if (!own_valid) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (Winc) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_q;

  // Count cycles where the owner has data but the FIFO refuses it.
  always_ff @(posedge W_CLK or negedge RST) begin
    if (!RST)
      stall_q <= '0;
    else if (busy && own_valid && FULL_flag && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester word queues act as
// sources, a transaction-level model predicts each cycle's handshake.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int GW = 2;

  logic               W_CLK = 1'b0;
  logic               RST;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               FULL_flag;
  logic               Winc;
  logic [DW-1:0]      WR_DATA;
  logic [GW-1:0]      grant_id;
  logic               busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]        stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Source queues and model state.
  logic [DW-1:0] srcq [NR][$];
  int  m_busy, m_grant, m_last, m_beats;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .W_CLK     (W_CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .FULL_flag (FULL_flag),
    .Winc      (Winc),
    .WR_DATA   (WR_DATA),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 W_CLK = ~W_CLK;

  task automatic push(input int r, input int n);
    for (int i = 0; i < n; i++) srcq[r].push_back(DW'($urandom));
  endtask

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_last = NR - 1; m_beats = 0;
  endtask

  // One clock cycle: drive sources, predict, compare, pop, advance model.
  // Entered and left at posedge+1.
  task automatic cycle(input logic full, output logic w_o, output logic b_o,
                       output logic [GW-1:0] g_o);
    logic [NR-1:0] v;
    logic [NR-1:0] exp_rdy;
    logic          exp_w;
    logic [DW-1:0] exp_d;
    FULL_flag = full;
    for (int i = 0; i < NR; i++) begin
      v[i] = (srcq[i].size() != 0);
      req_data[i*DW +: DW] = v[i] ? srcq[i][0] : '0;
    end
    req_valid = v;
    #3;
    exp_rdy = (m_busy != 0 && !full) ? (NR'(1) << m_grant) : '0;
    exp_w   = (m_busy != 0) && v[m_grant] && !full;
    exp_d   = (m_busy != 0 && v[m_grant]) ? srcq[m_grant][0] : '0;
    n_cmp++;
    if (busy !== (m_busy != 0)) begin
      n_bad++; $display("FAIL busy: got %b want %0d (t=%0t)", busy, m_busy, $time);
    end
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_bad++; $display("FAIL req_ready: got %b want %b (t=%0t)", req_ready, exp_rdy, $time);
    end
    n_cmp++;
    if (Winc !== exp_w) begin
      n_bad++; $display("FAIL Winc: got %b want %b (t=%0t)", Winc, exp_w, $time);
    end
    n_cmp++;
    if (WR_DATA !== exp_d) begin
      n_bad++; $display("FAIL WR_DATA: got %h want %h (t=%0t)", WR_DATA, exp_d, $time);
    end
    if (m_busy != 0) begin
      n_cmp++;
      if (grant_id !== GW'(m_grant)) begin
        n_bad++; $display("FAIL grant_id: got %0d want %0d (t=%0t)", grant_id, m_grant, $time);
      end
    end
    w_o = Winc; b_o = busy; g_o = grant_id;
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) void'(srcq[i].pop_front());
    // Model: arbitrate when idle; otherwise count writes and end the burst
    // at MAX_BURST words or when the owner runs dry.
    if (m_busy == 0) begin
      for (int k = NR; k >= 1; k--)
        if (v[(m_last + k) % NR]) begin
          m_grant = (m_last + k) % NR; m_busy = 1; m_beats = 0;
        end
    end else if (!v[m_grant]) begin
      m_busy = 0; m_last = m_grant;
    end else if (exp_w) begin
      m_beats++;
      if (m_beats == MB) begin m_busy = 0; m_last = m_grant; end
    end
    @(posedge W_CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; FULL_flag = 1'b0; req_valid = '0; req_data = '0;
    for (int i = 0; i < NR; i++) srcq[i].delete();
    model_reset();
    repeat (2) @(posedge W_CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0; FULL_flag = 1'b0; req_valid = '1; req_data = '1;
    #7;
    n_cmp++;
    if ({Winc, busy, req_ready, grant_id} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got W=%b b=%b r=%b g=%0d want all 0",
                        Winc, busy, req_ready, grant_id);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
    do_reset();
  endtask

  // Single requester, 6 words: one idle, 4 writes, one idle, 2 writes.
  task automatic test_single_burst();
    logic w, b; logic [GW-1:0] g;
    logic [8:0] tr;
    do_reset();
    push(2, 6);
    for (int c = 0; c < 9; c++) begin
      cycle(1'b0, w, b, g);
      tr[c] = w;
    end
    n_cmp++;
    if (tr !== 9'b011011110) begin
      n_bad++; $display("FAIL single_trace: got %b want %b", tr, 9'b011011110);
    end
  endtask

  // All requesters busy: grants 0,1,2,3,0 with 4 writes each.
  task automatic test_round_robin();
    logic w, b; logic [GW-1:0] g;
    int nw;
    int seq [$];
    do_reset();
    for (int i = 0; i < NR; i++) push(i, 20);
    nw = 0;
    for (int c = 0; c < 25; c++) begin
      cycle(1'b0, w, b, g);
      if (w) begin nw++; seq.push_back(int'(g)); end
    end
    n_cmp++;
    if (nw != 20) begin
      n_bad++; $display("FAIL rr_write_count: got %0d want 20", nw);
    end
    for (int i = 0; i < 20 && i < seq.size(); i++) begin
      n_cmp++;
      if (seq[i] != (i / 4) % NR) begin
        n_bad++; $display("FAIL rr_grant_seq[%0d]: got %0d want %0d", i, seq[i], (i / 4) % NR);
      end
    end
  endtask

  // FULL for 5 cycles after two words: stall, then finish the burst.
  task automatic test_full_stall();
    logic w, b; logic [GW-1:0] g;
    int nw, stall_ok;
    do_reset();
    push(1, 4);
    nw = 0; stall_ok = 1;
    for (int c = 0; c < 11; c++) begin
      cycle(c >= 3 && c <= 7, w, b, g);
      if (w) nw++;
      if (c >= 3 && c <= 7 && (w || !b || g != 1)) stall_ok = 0;
    end
    n_cmp++;
    if (stall_ok != 1) begin
      n_bad++; $display("FAIL full_stall_hold: got %0d want 1", stall_ok);
    end
    n_cmp++;
    if (nw != 4 || srcq[1].size() != 0) begin
      n_bad++; $display("FAIL full_stall_words: got %0d left %0d want 4 left 0", nw, srcq[1].size());
    end
`ifdef FIFO_WR_ARB_STATS_EN
    n_cmp++;
    if (stall_cnt !== 16'd5) begin
      n_bad++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
    end
`endif
  endtask

  // Owner 3 runs dry after one word; others arriving mid-burst are ignored,
  // then the search wraps to 0.
  task automatic test_early_exit();
    logic w, b; logic [GW-1:0] g;
    do_reset();
    push(3, 1);
    cycle(1'b0, w, b, g);
    push(0, 3); push(2, 3);
    cycle(1'b0, w, b, g);
    n_cmp++;
    if (w !== 1'b1 || g !== 2'd3) begin
      n_bad++; $display("FAIL exit_first_word: got w=%b g=%0d want w=1 g=3", w, g);
    end
    cycle(1'b0, w, b, g);
    n_cmp++;
    if (b !== 1'b1 || w !== 1'b0) begin
      n_bad++; $display("FAIL exit_dry_cycle: got b=%b w=%b want b=1 w=0", b, w);
    end
    cycle(1'b0, w, b, g);
    cycle(1'b0, w, b, g);
    n_cmp++;
    if (g !== 2'd0 || w !== 1'b1) begin
      n_bad++; $display("FAIL exit_wrap_grant: got g=%0d w=%b want g=0 w=1", g, w);
    end
  endtask

  // Reset in beat 2 of the second burst: outputs drop at once, 0 wins next.
  task automatic test_reset_mid_burst();
    logic w, b; logic [GW-1:0] g;
    do_reset();
    for (int i = 0; i < NR; i++) push(i, 10);
    for (int c = 0; c < 7; c++) cycle(1'b0, w, b, g);
    FULL_flag = 1'b0;
    #3;
    n_cmp++;
    if (Winc !== 1'b1 || grant_id !== 2'd1) begin
      n_bad++; $display("FAIL pre_reset_beat: got W=%b g=%0d want W=1 g=1", Winc, grant_id);
    end
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({Winc, busy, req_ready} !== '0) begin
      n_bad++; $display("FAIL async_reset_drop: got W=%b b=%b r=%b want 0", Winc, busy, req_ready);
    end
    model_reset();
    @(posedge W_CLK); #1;
    RST = 1'b1;
    cycle(1'b0, w, b, g);
    cycle(1'b0, w, b, g);
    n_cmp++;
    if (g !== 2'd0 || w !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_grant: got g=%0d w=%b want g=0 w=1", g, w);
    end
  endtask

  // Random traffic and random FULL against the model.
  task automatic test_random();
    logic w, b; logic [GW-1:0] g;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) push($urandom_range(0, NR - 1), $urandom_range(1, 6));
      cycle($urandom_range(0, 9) < 3, w, b, g);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_exit();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
